bram_stream_reader: RTL

- Read-side controller for the single-port block RAM used to hold KNN feature/training vectors.
- On a start command, it issues a burst of reads from a base address over a given length.
- It absorbs the RAM's 1-cycle registered read latency and presents the words on a valid/ready stream with a last-beat flag.
- It sits between the RAM instance and the distance-computation datapath.

---
 rtl/bram_stream_reader.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/bram_stream_reader.sv
// rtl/bram_stream_reader.sv - burst read controller for a single-port block RAM with valid/ready output
//
// Ports:
//   clock         rising-edge clock
//   reset_n       asynchronous active-low reset
//   start         burst request, sampled only while idle
//   base_address  first word address, sampled with start
//   length        word count 0..2**RAM_ADDR_BITS, sampled with start
//   busy          high from the accepted start until the final beat transfers
//   done          one-cycle pulse when the final beat transfers (or on a zero-length start)
//   ram_enable    RAM enable, high only on cycles that issue a read
//   write_enable  tied low, this block only reads
//   address       RAM read address
//   ram_data      RAM output data, valid the cycle after a ram_enable cycle
//   out_valid     stream data valid
//   out_ready     downstream accepts the beat
//   out_data      stream data
//   out_last      final beat of the burst, qualified by out_valid

module bram_stream_reader #(
  parameter int RAM_WIDTH     = 32,
  parameter int RAM_ADDR_BITS = 7
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [RAM_ADDR_BITS-1:0] base_address,
  input  logic [RAM_ADDR_BITS:0]   length,
  output logic                     busy,
  output logic                     done,
  output logic                     ram_enable,
  output logic                     write_enable,
  output logic [RAM_ADDR_BITS-1:0] address,
  input  logic [RAM_WIDTH-1:0]     ram_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [RAM_WIDTH-1:0]     out_data,
  output logic                     out_last
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state;

  // Burst bookkeeping: issue_cnt counts reads still to be issued, beat_cnt
  // counts beats still to be handed downstream.
  logic [RAM_ADDR_BITS-1:0] addr_q;
  logic [RAM_ADDR_BITS:0]   issue_cnt;
  logic [RAM_ADDR_BITS:0]   beat_cnt;
  logic                     busy_q;
  logic                     done_q;

  // One read is in flight when ram_enable was high last cycle; its last-beat
  // tag travels alongside so it lands in the FIFO with the data.
  logic in_flight;
  logic in_flight_last;

  // Two-entry output FIFO: enough to cover the one-cycle RAM latency while
  // still sustaining one beat per cycle.
  logic [RAM_WIDTH-1:0] fifo_data [2];
  logic [1:0]           fifo_last;
  logic                 wr_ptr;
  logic                 rd_ptr;
  logic [1:0]           fifo_count;

  logic       push;
  logic       pop;
  logic       issue_last;
  logic [2:0] committed;
  logic [2:0] room_limit;

  assign push       = in_flight;
  assign pop        = out_valid & out_ready;
  assign issue_last = (issue_cnt == {{RAM_ADDR_BITS{1'b0}}, 1'b1});

  // Entries held plus the read in flight, minus the one leaving this cycle,
  // must stay below two before another read may be issued. The pop is moved
  // to the right-hand side to keep the arithmetic unsigned.
  assign committed  = {1'b0, fifo_count} + {2'b00, in_flight};
  assign room_limit = 3'd2 + {2'b00, pop};

  assign ram_enable   = (state == READ) && (issue_cnt != '0) && (committed < room_limit);
  assign write_enable = 1'b0;
  assign address      = addr_q;

  assign out_valid = (fifo_count != 2'd0);
  assign out_data  = fifo_data[rd_ptr];
  assign out_last  = fifo_last[rd_ptr] & out_valid;

  assign busy = busy_q;
  assign done = done_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      addr_q         <= '0;
      issue_cnt      <= '0;
      beat_cnt       <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      in_flight      <= 1'b0;
      in_flight_last <= 1'b0;
      fifo_data[0]   <= '0;
      fifo_data[1]   <= '0;
      fifo_last      <= '0;
      wr_ptr         <= 1'b0;
      rd_ptr         <= 1'b0;
      fifo_count     <= 2'd0;
    end else begin
      done_q         <= 1'b0;
      in_flight      <= ram_enable;
      in_flight_last <= ram_enable & issue_last;

      // Data returning from the RAM lands in the FIFO one edge after issue.
      if (push) begin
        fifo_data[wr_ptr] <= ram_data;
        fifo_last[wr_ptr] <= in_flight_last;
        wr_ptr            <= ~wr_ptr;
      end

      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end

      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase

      // The address wraps naturally at the top of the RAM.
      if (ram_enable) begin
        addr_q    <= addr_q + 1'b1;
        issue_cnt <= issue_cnt - 1'b1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            if (length != '0) begin
              addr_q    <= base_address;
              issue_cnt <= length;
              beat_cnt  <= length;
              busy_q    <= 1'b1;
              state     <= READ;
            end else begin
              // Empty burst: acknowledge immediately without touching the RAM.
              done_q <= 1'b1;
            end
          end
        end
        READ: begin
          if (ram_enable && issue_last) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
        end
        default: begin
          state <= IDLE;
        end
      endcase

      // Completion is tied to the final beat leaving, whichever busy state
      // we happen to be in at that moment.
      if ((state != IDLE) && pop) begin
        beat_cnt <= beat_cnt - 1'b1;
        if (beat_cnt == {{RAM_ADDR_BITS{1'b0}}, 1'b1}) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
          state  <= IDLE;
        end
      end
    end
  end

endmodule
